branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Two-stage pipelined branch/jump resolver. It consumes register operands and instruction fields, derives the equal, less-than and less-than-unsigned flags, and decides taken/not-taken and the target PC.
- Sits between decode/execute and PC select, and is the consumer of the zero/equal flag logic.
- Uses a valid/ready handshake on both sides and supports a pipeline flush.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  kill all in-flight entries
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- in_pc  input  XLEN  instruction PC
- in_rs1  input  XLEN  operand 1
- in_rs2  input  XLEN  operand 2
- in_imm  input  XLEN  sign-extended offset
- in_funct3  input  3  branch condition
- in_is_branch  input  1  conditional branch
- in_is_jal  input  1  JAL
- in_is_jalr  input  1  JALR
- in_pred_taken  input  1  front-end prediction
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_taken  output  1  branch/jump taken
- out_target  output  XLEN  redirect PC
- out_link  output  XLEN  pc+4
- out_mispredict  output  1  out_taken != pred_taken
- out_illegal  output  1  unsupported funct3 on a branch
- out_misaligned  output  1  taken and target[1:0] != 0
- branch_cnt  output  CNT_W  completed conditional branches
- taken_cnt  output  CNT_W  completed taken conditional branches

Behaviour:
- Clocking: one clock (clk). Reset rst is synchronous, active-high. All state is sampled on the posedge of clk.
- Reset: s1_valid=0, s2_valid=0, out_valid=0. All out_* data outputs are 0. Counters are 0. in_ready=1 from the first cycle after reset deassertion.
- Stage S1 registers the request on in_valid&&in_ready. From those registered operands it computes:
  - eq = (rs1==rs2), built as an XOR/OR-reduce tree
  - lt = signed rs1<rs2
  - ltu = unsigned rs1<rs2
  - sum_pc = pc+imm
  - sum_rs = rs1+imm
  - link = pc+4
  
  All of these are registered into S2.
- Stage S2 drives the out_* signals directly from registers.
- Latency is 2 cycles from the accepting edge to out_valid, with no stalls. Throughput is 1 request per cycle.
- Handshake:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = (!s1_valid || s2 advances) && !flush.
  - out_* data is held stable while out_valid && !out_ready.
- Condition decode (conditional branch):
  - 000 taken=eq
  - 001 taken=!eq
  - 100 taken=lt
  - 101 taken=!lt
  - 110 taken=ltu
  - 111 taken=!ltu
  - 010/011: taken=0, illegal=1
- Targets:
  - Branch/JAL: target = sum_pc.
  - JALR: target = sum_rs & ~1. JALR is always taken.
  - Not taken: target = link.
- Arithmetic: all adds are modulo 2^XLEN, so 0xFFFFFFFC+4 = 0.
- Flag priority: if more than one of is_branch/is_jal/is_jalr is set, priority is jalr > jal > branch. If none is set: taken=0, target=link, illegal=0.
- out_mispredict = out_taken ^ pred_taken. It is valid for all request kinds.
- Flush:
  - Clears s1_valid and s2_valid on the same edge.
  - An in_valid presented during flush is not accepted, because in_ready=0.
  - out_valid=0 on the cycle after flush.
  - Counters are unaffected.
- Simultaneous flush and out_ready: the output handshake in that cycle still completes and is counted. Flush affects state only at the edge.
- Counters:
  - Increment on out_valid&&out_ready for conditional branches only.
  - taken_cnt additionally requires out_taken.
  - Both wrap modulo 2^CNT_W.
  - Cleared only by rst.
- Reset mid-operation: all entries are dropped and counters are cleared. No output handshake completes on the reset edge.

Decomposition:
- branch_pkg holds:
  - the funct3 localparams (F3_BEQ…F3_BGEU)
  - a packed struct s1_payload_t (pc, rs1, rs2, imm, funct3, kind, pred)
  - a packed struct s2_payload_t (taken, target, link, mispredict, illegal, misaligned)
- Sub-module branch_cmp32 computes eq/lt/ltu combinationally. It is instantiated in S1.

Test Plan:
- BEQ rs1=rs2=0x1234, pc=0x100, imm=0x20, pred=0 -> 2 cycles later out_taken=1, target=0x120, link=0x104, mispredict=1.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1. Same operands with BLTU -> taken=0, target=pc+4.
- JALR rs1=0x2003, imm=0x10 -> taken=1, target=0x2012, misaligned=1. Also pc=0xFFFFFFFC, JAL imm=8 -> target=0x4, link=0x0.
- Back-to-back 4 branches with out_ready low for 3 cycles -> in_ready drops after 2 accepts, the first output is held stable, all 4 emerge in order, and branch_cnt=4.
- funct3=010 branch -> illegal=1, taken=0, branch_cnt increments. Flush with 2 entries in flight -> out_valid=0 next cycle and counters unchanged.
- rst asserted mid-stream with s1 and s2 full -> next cycle out_valid=0, in_ready=1, branch_cnt=0, taken_cnt=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and funct3 decode for the branch resolver.
package branch_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_BRANCH,
    KIND_JAL,
    KIND_JALR
  } kind_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [DATA_W-1:0] imm;
    logic [2:0]        funct3;
    kind_t             kind;
    logic              pred;
  } s1_payload_t;

  typedef struct packed {
    logic              taken;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] link;
    logic              mispredict;
    logic              illegal;
    logic              misaligned;
  } s2_payload_t;

  // Multiple kind flags resolve as jalr > jal > branch.
  function automatic kind_t decode_kind(input logic br, input logic jal, input logic jalr);
    if (jalr)     return KIND_JALR;
    else if (jal) return KIND_JAL;
    else if (br)  return KIND_BRANCH;
    else          return KIND_NONE;
  endfunction

  // Returns {illegal, taken} for a conditional branch.
  function automatic logic [1:0] branch_cond(input logic [2:0] f3, input logic eq,
                                             input logic lt, input logic ltu);
    case (f3)
      F3_BEQ:  return {1'b0, eq};
      F3_BNE:  return {1'b0, !eq};
      F3_BLT:  return {1'b0, lt};
      F3_BGE:  return {1'b0, !lt};
      F3_BLTU: return {1'b0, ltu};
      F3_BGEU: return {1'b0, !ltu};
      default: return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/response bus of the branch resolver; master issues requests and consumes results.
interface branch_resolve_unit_if;
  import branch_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_rs1;
  logic [DATA_W-1:0] in_rs2;
  logic [DATA_W-1:0] in_imm;
  logic [2:0]        in_funct3;
  logic              in_is_branch;
  logic              in_is_jal;
  logic              in_is_jalr;
  logic              in_pred_taken;
  logic              out_valid;
  logic              out_ready;
  logic              out_taken;
  logic [DATA_W-1:0] out_target;
  logic [DATA_W-1:0] out_link;
  logic              out_mispredict;
  logic              out_illegal;
  logic              out_misaligned;

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_imm, in_funct3,
           in_is_branch, in_is_jal, in_is_jalr, in_pred_taken, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_link,
           out_mispredict, out_illegal, out_misaligned
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_imm, in_funct3,
           in_is_branch, in_is_jal, in_is_jalr, in_pred_taken, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_link,
           out_mispredict, out_illegal, out_misaligned
  );

endinterface

// File: rtl/branch_cmp32.sv
// Combinational equal / signed-less-than / unsigned-less-than flags for two operands.
module branch_cmp32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = ~|(a ^ b);
  assign lt  = $signed(a) < $signed(b);
  assign ltu = a < b;

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch/jump resolver: S1 holds the request and resolves it, S2 holds the result.
// Two cycles from accept to out_valid, one request per cycle; flush kills S1/S2 at the edge.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = DATA_W,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0]     branch_cnt,
  output logic [CNT_W-1:0]     taken_cnt
);

  logic        s1_valid, s2_valid, s2_branch;
  s1_payload_t s1_q;
  s2_payload_t s2_q, s1_res;
  logic        s1_adv, s2_adv, out_fire;
  logic        eq, lt, ltu, taken, illegal;
  logic [XLEN-1:0] sum_pc, sum_rs, link, target;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv && !flush;
  assign out_fire     = s2_valid && bus.out_ready;

  branch_cmp32 u_cmp (
    .a   (s1_q.rs1),
    .b   (s1_q.rs2),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  always_comb begin
    sum_pc  = s1_q.pc + s1_q.imm;
    sum_rs  = s1_q.rs1 + s1_q.imm;
    link    = s1_q.pc + 32'd4;
    taken   = 1'b0;
    illegal = 1'b0;
    target  = link;
    case (s1_q.kind)
      KIND_JALR: begin
        taken  = 1'b1;
        target = {sum_rs[XLEN-1:1], 1'b0};
      end
      KIND_JAL: begin
        taken  = 1'b1;
        target = sum_pc;
      end
      KIND_BRANCH: begin
        {illegal, taken} = branch_cond(s1_q.funct3, eq, lt, ltu);
        if (taken) target = sum_pc;
      end
      default: ;
    endcase
    s1_res.taken      = taken;
    s1_res.target     = target;
    s1_res.link       = link;
    s1_res.mispredict = taken ^ s1_q.pred;
    s1_res.illegal    = illegal;
    s1_res.misaligned = taken && (target[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s2_branch  <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      // A handshake in the flush cycle still completes, so counting ignores flush.
      if (out_fire && s2_branch) begin
        branch_cnt <= branch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (s2_q.taken) taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s2_adv) begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_q      <= s1_res;
            s2_branch <= (s1_q.kind == KIND_BRANCH);
          end
        end
        if (s1_adv) begin
          s1_valid <= bus.in_valid;
          if (bus.in_valid) begin
            s1_q <= '{pc: bus.in_pc, rs1: bus.in_rs1, rs2: bus.in_rs2, imm: bus.in_imm,
                      funct3: bus.in_funct3,
                      kind: decode_kind(bus.in_is_branch, bus.in_is_jal, bus.in_is_jalr),
                      pred: bus.in_pred_taken};
          end
        end
      end
    end
  end

  assign bus.out_valid      = s2_valid;
  assign bus.out_taken      = s2_q.taken;
  assign bus.out_target     = s2_q.target;
  assign bus.out_link       = s2_q.link;
  assign bus.out_mispredict = s2_q.mispredict;
  assign bus.out_illegal    = s2_q.illegal;
  assign bus.out_misaligned = s2_q.misaligned;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: expected results queued on accept, popped and compared on each output handshake.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        misp;
    logic        ill;
    logic        misal;
    logic        br;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] branch_cnt, taken_cnt;

  branch_resolve_unit_if bus();

  branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  exp_t        pend_exp = '0;
  logic [31:0] exp_bcnt = '0;
  logic [31:0] exp_tcnt = '0;
  logic        rand_rdy = 1'b0;
  logic        rdy_force = 1'b1;
  logic        holding = 1'b0;
  logic [67:0] held = '0;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic tk, input logic [31:0] tgt, input logic [31:0] lnk,
                              input logic mp, input logic il, input logic ma, input logic br);
    exp_t e;
    e = '{taken: tk, target: tgt, link: lnk, misp: mp, ill: il, misal: ma, br: br};
    return e;
  endfunction

  // Reference resolution straight from the ISA rules.
  function automatic exp_t ref_model(input logic [31:0] pc, input logic [31:0] rs1,
                                     input logic [31:0] rs2, input logic [31:0] imm,
                                     input logic [2:0] f3, input logic br, input logic jal,
                                     input logic jalr, input logic pred);
    exp_t e;
    logic c;
    e = '0;
    e.link = pc + 32'd4;
    e.target = e.link;
    if (jalr) begin
      e.taken = 1'b1;
      e.target = (rs1 + imm) & 32'hFFFF_FFFE;
    end else if (jal) begin
      e.taken = 1'b1;
      e.target = pc + imm;
    end else if (br) begin
      e.br = 1'b1;
      case (f3)
        3'd0: c = (rs1 == rs2);
        3'd1: c = (rs1 != rs2);
        3'd4: c = ($signed(rs1) < $signed(rs2));
        3'd5: c = ($signed(rs1) >= $signed(rs2));
        3'd6: c = (rs1 < rs2);
        3'd7: c = (rs1 >= rs2);
        default: begin c = 1'b0; e.ill = 1'b1; end
      endcase
      e.taken = c;
      if (c) e.target = pc + imm;
    end
    e.misp = e.taken ^ pred;
    e.misal = e.taken && (e.target[1:0] != 2'b00);
    return e;
  endfunction

  function automatic logic [67:0] cur_out();
    return {bus.out_taken, bus.out_target, bus.out_link,
            bus.out_mispredict, bus.out_illegal, bus.out_misaligned};
  endfunction

  // Monitor: everything sampled at the negedge, i.e. what the next posedge will see.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      exp_bcnt = '0;
      exp_tcnt = '0;
      holding = 1'b0;
    end else begin
      if (holding) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_data", cur_out(), held);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("cnt_branch", branch_cnt, exp_bcnt);
        check("cnt_taken", taken_cnt, exp_tcnt);
        if (q.size() == 0) begin
          check("spurious_out", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          check("taken", bus.out_taken, e.taken);
          check("target", bus.out_target, e.target);
          check("link", bus.out_link, e.link);
          check("mispredict", bus.out_mispredict, e.misp);
          check("illegal", bus.out_illegal, e.ill);
          check("misaligned", bus.out_misaligned, e.misal);
          if (e.br) begin
            exp_bcnt = exp_bcnt + 32'd1;
            if (e.taken) exp_tcnt = exp_tcnt + 32'd1;
          end
        end
      end
      holding = bus.out_valid && !bus.out_ready && !flush;
      held = cur_out();
      if (flush) q.delete();
      if (bus.in_valid && bus.in_ready) q.push_back(pend_exp);
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic [2:0] f3, input logic br,
                      input logic jal, input logic jalr, input logic pred, input exp_t e);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_pc = pc;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_imm = imm;
    bus.in_funct3 = f3;
    bus.in_is_branch = br;
    bus.in_is_jal = jal;
    bus.in_is_jalr = jalr;
    bus.in_pred_taken = pred;
    pend_exp = e;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic rand_send();
    logic [31:0] pc, rs1, rs2, imm, r;
    logic [2:0]  f3;
    logic        br, jal, jalr, pred;
    r    = $urandom;
    pc   = $urandom & 32'hFFFF_FFFC;
    rs1  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
    rs2  = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
    imm  = ($urandom_range(0, 3) == 0) ? $urandom : {{20{r[11]}}, r[11:0]};
    f3   = 3'($urandom_range(0, 7));
    br   = ($urandom_range(0, 3) != 0);
    jal  = ($urandom_range(0, 5) == 0);
    jalr = ($urandom_range(0, 5) == 0);
    pred = 1'($urandom_range(0, 1));
    send(pc, rs1, rs2, imm, f3, br, jal, jalr, pred,
         ref_model(pc, rs1, rs2, imm, f3, br, jal, jalr, pred));
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_imm = '0;
    bus.in_funct3 = '0;
    bus.in_is_branch = 1'b0;
    bus.in_is_jal = 1'b0;
    bus.in_is_jalr = 1'b0;
    bus.in_pred_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", cur_out(), 68'h0);
    check("rst_counters", {branch_cnt, taken_cnt}, 64'h0);
    check("rst_in_ready", bus.in_ready, 1'b1);

    // BEQ equal, checked for exact latency
    send(32'h100, 32'h1234, 32'h1234, 32'h20, F3_BEQ, 1, 0, 0, 0,
         mk(1, 32'h120, 32'h104, 1, 0, 0, 1));
    check("lat_early", bus.out_valid, 1'b0);
    step();
    check("lat_two_cycles", bus.out_valid, 1'b1);
    check("beq_target", bus.out_target, 32'h120);
    send(32'h200, 32'hFFFF_FFFF, 32'h1, 32'h10, F3_BLT, 1, 0, 0, 1,
         mk(1, 32'h210, 32'h204, 0, 0, 0, 1));
    send(32'h300, 32'hFFFF_FFFF, 32'h1, 32'h10, F3_BLTU, 1, 0, 0, 1,
         mk(0, 32'h304, 32'h304, 1, 0, 0, 1));
    // JALR with branch/jal also set: jalr wins, not counted as a branch
    send(32'h400, 32'h2003, 32'h0, 32'h10, F3_BEQ, 1, 1, 1, 1,
         mk(1, 32'h2012, 32'h404, 0, 0, 1, 0));
    send(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h8, F3_BEQ, 0, 1, 0, 0,
         mk(1, 32'h4, 32'h0, 1, 0, 0, 0));
    repeat (4) step();

    // Back-to-back with the consumer stalled
    rdy_force = 1'b0;
    step();
    for (int i = 0; i < 2; i++)
      send(32'h500 + 32'(16 * i), 32'(i), 32'h0, 32'h40, F3_BEQ, 1, 0, 0, 0,
           (i == 0) ? mk(1, 32'h540, 32'h504, 1, 0, 0, 1)
                    : mk(0, 32'h514, 32'h514, 0, 0, 0, 1));
    check("b2b_in_ready_low", bus.in_ready, 1'b0);
    repeat (3) step();
    check("b2b_still_blocked", bus.in_ready, 1'b0);
    check("b2b_first_held", bus.out_target, 32'h540);
    rdy_force = 1'b1;
    for (int i = 2; i < 4; i++)
      send(32'h500 + 32'(16 * i), 32'(i), 32'h0, 32'h40, F3_BEQ, 1, 0, 0, 0,
           mk(0, 32'h504 + 32'(16 * i), 32'h504 + 32'(16 * i), 0, 0, 0, 1));
    repeat (4) step();
    check("b2b_branch_cnt", branch_cnt, 32'd7);
    check("b2b_taken_cnt", taken_cnt, 32'd3);

    send(32'h600, 32'h5, 32'h5, 32'h40, 3'b010, 1, 0, 0, 0,
         mk(0, 32'h604, 32'h604, 0, 1, 0, 1));
    repeat (3) step();
    check("illegal_branch_cnt", branch_cnt, 32'd8);

    // Flush with both stages occupied
    rdy_force = 1'b0;
    step();
    send(32'h700, 32'h1, 32'h1, 32'h8, F3_BEQ, 1, 0, 0, 0, mk(1, 32'h708, 32'h704, 1, 0, 0, 1));
    send(32'h710, 32'h1, 32'h1, 32'h8, F3_BEQ, 1, 0, 0, 0, mk(1, 32'h718, 32'h714, 1, 0, 0, 1));
    flush = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_counters", {branch_cnt, taken_cnt}, {32'd8, 32'd3});
    rdy_force = 1'b1;
    repeat (3) step();

    // Reset while both stages are full
    rdy_force = 1'b0;
    step();
    send(32'h800, 32'h1, 32'h2, 32'h8, F3_BNE, 1, 0, 0, 0, mk(1, 32'h808, 32'h804, 1, 0, 0, 1));
    send(32'h810, 32'h1, 32'h2, 32'h8, F3_BNE, 1, 0, 0, 0, mk(1, 32'h818, 32'h814, 1, 0, 0, 1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_counters", {branch_cnt, taken_cnt}, 64'h0);
    rdy_force = 1'b1;
    step();

    // Randomized traffic with random consumer stalls and occasional flushes
    rand_rdy = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        rand_send();
      end
    end
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      step();
    end
    step();
    check("drain_empty", q.size(), 0);
    check("final_branch_cnt", branch_cnt, exp_bcnt);
    check("final_taken_cnt", taken_cnt, exp_tcnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
